// File: rtl/if_fetch_if.sv
// Byte-wide instruction memory port between the fetch stage (master) and the memory arbiter (slave).
interface if_fetch_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [7:0]  mem_data_i;

    modport master (output mem_req_o, output mem_addr_o, input mem_ack_i, input mem_data_i);
    modport slave  (input mem_req_o, input mem_addr_o, output mem_ack_i, output mem_data_i);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit little-endian words from a byte-wide memory port.
// Optional direct-mapped I-cache is built when IF_ICACHE_EN is defined.
module if_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_enable_i,
    input  logic [31:0] branch_addr_i,
    if_fetch_if.master  mem,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stallreq_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;

    logic        redirect_s;
    logic        last_ack_s;
    logic [31:0] word_s;
    logic        hit_s;
    logic [31:0] hit_word_s;

    if ((ICACHE_LINES < 32'd2) || ((ICACHE_LINES & (ICACHE_LINES - 32'd1)) != 32'd0)) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of 2");
    end

    assign redirect_s = !stall_i && branch_enable_i;
    assign last_ack_s = (state_q == FETCH) && mem.mem_ack_i && (byte_cnt_q == 2'd3);
    assign word_s     = {mem.mem_data_i, inst_buf_q[23:0]};

`ifdef IF_ICACHE_EN
    localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [31:0]             cache_data_q [ICACHE_LINES];
    logic [TAG_W-1:0]        cache_tag_q  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] cache_valid_q;
    logic [IDX_W-1:0]        rd_idx_s, wr_idx_s;
    logic                    fill_s;

    assign rd_idx_s   = pc_q[2 +: IDX_W];
    assign wr_idx_s   = fetch_pc_q[2 +: IDX_W];
    // Only word-aligned PCs use the cache; the tag does not cover pc[1:0].
    assign hit_s      = cache_valid_q[rd_idx_s] && (pc_q[1:0] == 2'b00)
                        && (cache_tag_q[rd_idx_s] == pc_q[31 -: TAG_W]);
    assign hit_word_s = cache_data_q[rd_idx_s];
    assign fill_s     = last_ack_s && !redirect_s && (fetch_pc_q[1:0] == 2'b00);

    // Cache valid bits, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid_q <= '0;
        end else if (fill_s) begin
            cache_valid_q[wr_idx_s] <= 1'b1;
        end
    end

    // Cache data and tag storage, written on a completed miss
    always_ff @(posedge clk) begin
        if (fill_s) begin
            cache_data_q[wr_idx_s] <= word_s;
            cache_tag_q[wr_idx_s]  <= fetch_pc_q[31 -: TAG_W];
        end
    end
`else
    assign hit_s      = 1'b0;
    assign hit_word_s = 32'h0000_0000;
`endif

    // Next-state and output computation; a sampled redirect overrides the state machine
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        inst_buf_d = inst_buf_q;
        byte_cnt_d = byte_cnt_q;
        pc_out_d   = pc_out_q;
        inst_out_d = inst_out_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                if (!stall_i) begin
                    if (hit_s) begin
                        pc_out_d   = pc_q;
                        inst_out_d = hit_word_s;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = READY;
                    end else begin
                        fetch_pc_d = pc_q;
                        byte_cnt_d = 2'd0;
                        state_d    = FETCH;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (mem.mem_ack_i) begin
                    inst_buf_d[{byte_cnt_q, 3'b000} +: 8] = mem.mem_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        pc_out_d   = fetch_pc_q;
                        inst_out_d = word_s;
                        valid_d    = 1'b1;
                        pc_d       = fetch_pc_q + 32'd4;
                        state_d    = READY;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    state_d = FETCH;
                end
            end
            READY: begin
                if (!stall_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (redirect_s) begin
            pc_d       = branch_addr_i;
            pc_out_d   = pc_out_q;
            inst_out_d = inst_out_q;
            valid_d    = 1'b0;
            byte_cnt_d = 2'd0;
            state_d    = IDLE;
        end else begin
            pc_d = pc_d;
        end
        req_d  = (state_d == FETCH);
        addr_d = fetch_pc_d + {30'd0, byte_cnt_d};
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= 32'h0000_0000;
            inst_buf_q <= 32'h0000_0000;
            byte_cnt_q <= 2'd0;
            pc_out_q   <= 32'h0000_0000;
            inst_out_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            inst_buf_q <= inst_buf_d;
            byte_cnt_q <= byte_cnt_d;
            pc_out_q   <= pc_out_d;
            inst_out_q <= inst_out_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
        end
    end

    assign mem.mem_req_o  = req_q;
    assign mem.mem_addr_o = addr_q;
    assign pc_o           = pc_out_q;
    assign inst_o         = inst_out_q;
    assign inst_valid_o   = valid_q;
    assign stallreq_o     = req_q;
endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: expected instructions and memory addresses are queued by the
// stimulus and popped by negedge monitors. Define IF_ICACHE_EN to also exercise the I-cache.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_enable_i;
    logic [31:0] branch_addr_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stallreq_o;
    logic        ack_block;
    logic [7:0]  mem_b [512];

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(32'h0000_0000), .ICACHE_LINES(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_enable_i (branch_enable_i),
        .branch_addr_i   (branch_addr_i),
        .mem             (bus.master),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o),
        .stallreq_o      (stallreq_o)
    );

    always #5 clk = ~clk;

    assign bus.mem_ack_i  = bus.mem_req_o & ~ack_block;
    assign bus.mem_data_i = mem_b[bus.mem_addr_o[8:0]];

    int n_vec = 0;
    int n_bad = 0;
    int req_cycles = 0;
    logic [63:0] exp_q [$];
    logic [31:0] addr_q [$];
    logic valid_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        mem_b[a]     = w[7:0];
        mem_b[a + 1] = w[15:8];
        mem_b[a + 2] = w[23:16];
        mem_b[a + 3] = w[31:24];
    endtask

    task automatic push_addrs(input logic [31:0] base);
        for (int i = 0; i < 4; i++) addr_q.push_back(base + i);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (inst_valid_o) break;
        end
        chk("valid_seen", {31'd0, inst_valid_o}, 32'd1);
    endtask

    task automatic wait_addr(input logic [31:0] a);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.mem_req_o && bus.mem_addr_o == a) break;
        end
        chk("wait_addr", bus.mem_addr_o, a);
    endtask

    // Return to IDLE after a one-cycle presentation, then park there with stall_i high
    task automatic park();
        tick();
        chk("valid_one_cycle", {31'd0, inst_valid_o}, 32'd0);
        stall_i = 1'b1;
    endtask

    // Instruction monitor: each rising inst_valid_o is one presented instruction
    always @(negedge clk) begin
        if (inst_valid_o && !valid_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_inst_pc", pc_o, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("inst_pc", pc_o, e[63:32]);
                chk("inst_word", inst_o, e[31:0]);
            end
        end
        valid_prev <= inst_valid_o;
    end

    // Memory monitor: every acked byte request must match the next expected address
    always @(negedge clk) begin
        if (bus.mem_req_o) req_cycles++;
        if (bus.mem_req_o && bus.mem_ack_i) begin
            if (addr_q.size() == 0) begin
                chk("unexpected_access", bus.mem_addr_o, 32'hDEAD_DEAD);
            end else begin
                chk("mem_addr", bus.mem_addr_o, addr_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int req_snap;
        for (int i = 0; i < 512; i++) mem_b[i] = 8'h00;
        put_word(32'h000, 32'h00A0_0513);
        put_word(32'h004, 32'h0010_0093);
        put_word(32'h008, 32'h0020_8133);
        put_word(32'h00C, 32'h0000_006F);
        put_word(32'h010, 32'h5555_AAAA);
        put_word(32'h040, 32'h0000_0013);
        put_word(32'h044, 32'hFE1F_F06F);
        put_word(32'h100, 32'h1234_5678);
        put_word(32'h104, 32'hDEAD_BEEF);
        put_word(32'h140, 32'hA5A5_A5A5);
        put_word(32'h1FC, 32'h0BAD_C0DE);
        rst = 1'b1; stall_i = 1'b1; branch_enable_i = 1'b0;
        branch_addr_i = 32'h0; ack_block = 1'b0;
        tick(); tick();
        chk("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("rst_addr", bus.mem_addr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
        rst = 1'b0;
        tick(); tick();
        chk("park_no_req", {31'd0, bus.mem_req_o}, 32'd0);

        // First fetch with a no-wait-state memory
        push_addrs(32'h0); exp_q.push_back({32'h0, 32'h00A0_0513});
        stall_i = 1'b0;
        wait_valid(lat);
        chk("latency_first", lat, 32'd5);
        chk("ready_stallreq", {31'd0, stallreq_o}, 32'd0);
        park();

        // Ack withheld three cycles on byte 2
        push_addrs(32'h4); exp_q.push_back({32'h4, 32'h0010_0093});
        stall_i = 1'b0;
        wait_addr(32'h6);
        ack_block = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_addr", bus.mem_addr_o, 32'h6);
            chk("hold_stallreq", {31'd0, stallreq_o}, 32'd1);
        end
        ack_block = 1'b0;
        wait_valid(lat);
        park();

        // Stall for five cycles in READY, then resume at pc+4
        push_addrs(32'h8); exp_q.push_back({32'h8, 32'h0020_8133});
        stall_i = 1'b0;
        wait_valid(lat);
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz_valid", {31'd0, inst_valid_o}, 32'd1);
            chk("frz_pc", pc_o, 32'h8);
            chk("frz_inst", inst_o, 32'h0020_8133);
            chk("frz_req", {31'd0, bus.mem_req_o}, 32'd0);
        end
        push_addrs(32'hC); exp_q.push_back({32'hC, 32'h0000_006F});
        stall_i = 1'b0;
        wait_valid(lat);
        park();

        // Redirect during byte 1, then redirect on a 4th-byte ack and wrap past 0xFFFFFFFC
        addr_q.push_back(32'h10); addr_q.push_back(32'h11);
        push_addrs(32'h100); exp_q.push_back({32'h100, 32'h1234_5678});
        push_addrs(32'h104);
        push_addrs(32'hFFFF_FFFC); exp_q.push_back({32'hFFFF_FFFC, 32'h0BAD_C0DE});
        push_addrs(32'h0); exp_q.push_back({32'h0, 32'h00A0_0513});
        stall_i = 1'b0;
        wait_addr(32'h11);
        branch_enable_i = 1'b1; branch_addr_i = 32'h100;
        tick();
        branch_enable_i = 1'b0;
        chk("redir_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("redir_valid", {31'd0, inst_valid_o}, 32'd0);
        wait_valid(lat);
        chk("latency_redir", lat, 32'd5);
        wait_addr(32'h107);
        branch_enable_i = 1'b1; branch_addr_i = 32'hFFFF_FFFC;
        tick();
        branch_enable_i = 1'b0;
        chk("drop_valid", {31'd0, inst_valid_o}, 32'd0);
        wait_valid(lat);
        wait_valid(lat);
        park();

        // Reset pulsed mid-fetch
        push_addrs(32'h4); void'(addr_q.pop_back());
        stall_i = 1'b0;
        wait_addr(32'h6);
        rst = 1'b1;
        tick();
        chk("mrst_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("mrst_addr", bus.mem_addr_o, 32'h0);
        chk("mrst_pc", pc_o, 32'h0);
        chk("mrst_inst", inst_o, 32'h0);
        chk("mrst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("mrst_stallreq", {31'd0, stallreq_o}, 32'd0);
        rst = 1'b0;
        push_addrs(32'h0); exp_q.push_back({32'h0, 32'h00A0_0513});
        wait_valid(lat);
        chk("latency_after_rst", lat, 32'd5);
        park();

`ifdef IF_ICACHE_EN
        // Loop at 0x40 run twice; second pass hits; alias at 0x140 misses
        stall_i = 1'b0; branch_enable_i = 1'b1; branch_addr_i = 32'h40;
        tick();
        branch_enable_i = 1'b0;
        push_addrs(32'h40); exp_q.push_back({32'h40, 32'h0000_0013});
        push_addrs(32'h44); exp_q.push_back({32'h44, 32'hFE1F_F06F});
        wait_valid(lat);
        wait_valid(lat);
        branch_enable_i = 1'b1; branch_addr_i = 32'h40;
        tick();
        branch_enable_i = 1'b0;
        req_snap = req_cycles;
        exp_q.push_back({32'h40, 32'h0000_0013});
        exp_q.push_back({32'h44, 32'hFE1F_F06F});
        wait_valid(lat);
        chk("hit_latency", lat, 32'd1);
        wait_valid(lat);
        chk("hit_latency2", lat, 32'd2);
        branch_enable_i = 1'b1; branch_addr_i = 32'h140;
        tick();
        branch_enable_i = 1'b0;
        chk("hit_no_req", req_cycles, req_snap);
        push_addrs(32'h140); exp_q.push_back({32'h140, 32'hA5A5_A5A5});
        wait_valid(lat);
        chk("alias_miss_latency", lat, 32'd5);
        park();
`endif

        tick(); tick();
        chk("exp_left", exp_q.size(), 32'd0);
        chk("addr_left", addr_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
